// File: rtl/cp0_exc_unit_if.sv
// Commit-stage bus between the pipeline and the CP0 exception unit.
// The pipeline side drives the master modport, the CP0 unit sits on the slave modport.
interface cp0_exc_unit_if #(
   parameter int unsigned HW_INT_NUM = 6
);
   logic [4:0]            cp0_read_addr_i;
   logic                  cp0_write_enable_i;
   logic [4:0]            cp0_write_addr_i;
   logic [31:0]           cp0_write_data_i;
   logic                  inst_valid_i;
   logic [6:0]            exception_type_i;
   logic                  eret_i;
   logic [31:0]           pc_i;
   logic [31:0]           bad_addr_i;
   logic                  in_delayslot_i;
   logic [HW_INT_NUM-1:0] int_i;
   logic [31:0]           cp0_read_data_o;
   logic [31:0]           cp0_return_pc_o;
   logic                  flush_o;
   logic                  timer_int_o;
   logic [31:0]           cp0_status_o;
   logic [31:0]           cp0_cause_o;
   logic [31:0]           cp0_epc_o;

   modport master (
      output cp0_read_addr_i, cp0_write_enable_i, cp0_write_addr_i, cp0_write_data_i,
      output inst_valid_i, exception_type_i, eret_i, pc_i, bad_addr_i, in_delayslot_i, int_i,
      input  cp0_read_data_o, cp0_return_pc_o, flush_o, timer_int_o,
      input  cp0_status_o, cp0_cause_o, cp0_epc_o
   );

   modport slave (
      input  cp0_read_addr_i, cp0_write_enable_i, cp0_write_addr_i, cp0_write_data_i,
      input  inst_valid_i, exception_type_i, eret_i, pc_i, bad_addr_i, in_delayslot_i, int_i,
      output cp0_read_data_o, cp0_return_pc_o, flush_o, timer_int_o,
      output cp0_status_o, cp0_cause_o, cp0_epc_o
   );
endinterface

// File: rtl/cp0_exc_unit.sv
// CP0 register file with timer, interrupt sampling and commit-stage exception/ERET handling.
// Accepted events raise a one-cycle flush, then one SQUASH cycle ignores the squashed commits.
module cp0_exc_unit #(
   parameter int unsigned HW_INT_NUM = 6,
   parameter int unsigned COUNT_DIV  = 2,
   parameter logic [31:0] EXC_VECTOR = 32'hBFC0_0380
) (
   input logic         clk,
   input logic         rst,
   cp0_exc_unit_if.slave bus
);
   localparam logic [31:0] StatusMask  = 32'h0000_FF03;
   localparam logic [31:0] CauseMask   = 32'h0000_0300;
   localparam logic [31:0] StatusReset = 32'h0040_0000;
   localparam logic [31:0] DivLast     = 32'(COUNT_DIV - 1);

   localparam logic [4:0] AddrBadVAddr = 5'd8;
   localparam logic [4:0] AddrCount    = 5'd9;
   localparam logic [4:0] AddrCompare  = 5'd11;
   localparam logic [4:0] AddrStatus   = 5'd12;
   localparam logic [4:0] AddrCause    = 5'd13;
   localparam logic [4:0] AddrEpc      = 5'd14;

   typedef enum logic [0:0] {StRun, StSquash} state_e;

   state_e      state_q, state_d;
   logic [31:0] badvaddr_q, badvaddr_d;
   logic [31:0] count_q, count_d;
   logic [31:0] compare_q, compare_d;
   logic [31:0] status_q, status_d;
   logic [31:0] cause_q, cause_d;
   logic [31:0] epc_q, epc_d;
   logic [31:0] presc_q, presc_d;
   logic        flush_q, flush_d;
   logic [31:0] ret_pc_q, ret_pc_d;

   logic        int_pend, accept, is_int, is_eret, bad_wr, wr_en, tick, ti;
   logic [4:0]  exc_code;
   logic [31:0] bad_val, rd_data;
   logic [5:0]  int_ext;

   // Zero-extend so lines above HW_INT_NUM sample as 0.
   assign int_ext = 6'(bus.int_i);

   always_comb begin
      rd_data = '0;
      unique case (bus.cp0_read_addr_i)
         AddrBadVAddr: rd_data = badvaddr_q;
         AddrCount:    rd_data = count_q;
         AddrCompare:  rd_data = compare_q;
         AddrStatus:   rd_data = status_q;
         AddrCause:    rd_data = cause_q;
         AddrEpc:      rd_data = epc_q;
         default:      rd_data = '0;
      endcase
      if (bus.cp0_write_enable_i && (bus.cp0_write_addr_i == bus.cp0_read_addr_i)) begin
         unique case (bus.cp0_read_addr_i)
            AddrCount, AddrCompare, AddrEpc: rd_data = bus.cp0_write_data_i;
            AddrStatus: rd_data = (status_q & ~StatusMask) | (bus.cp0_write_data_i & StatusMask);
            AddrCause:  rd_data = (cause_q & ~CauseMask) | (bus.cp0_write_data_i & CauseMask);
            default:    ;
         endcase
      end
   end

   always_comb begin
      state_d    = StRun;
      badvaddr_d = badvaddr_q;
      count_d    = count_q;
      compare_d  = compare_q;
      status_d   = status_q;
      cause_d    = cause_q;
      epc_d      = epc_q;
      presc_d    = presc_q;
      flush_d    = 1'b0;
      ret_pc_d   = '0;
      accept     = 1'b0;
      is_int     = 1'b0;
      is_eret    = 1'b0;
      bad_wr     = 1'b0;
      bad_val    = '0;
      exc_code   = 5'h00;

      int_pend = (|(cause_q[15:8] & status_q[15:8])) & status_q[0] & ~status_q[1]
                 & bus.inst_valid_i;

      if (state_q == StRun) begin
         accept = 1'b1;
         if (int_pend) begin
            is_int = 1'b1;
         end else if (bus.exception_type_i[0]) begin
            exc_code = 5'h04;
            bad_wr   = 1'b1;
            bad_val  = bus.pc_i;
         end else if (bus.exception_type_i[1]) begin
            exc_code = 5'h0A;
         end else if (bus.exception_type_i[2]) begin
            exc_code = 5'h0C;
         end else if (bus.exception_type_i[3]) begin
            exc_code = 5'h09;
         end else if (bus.exception_type_i[4]) begin
            exc_code = 5'h08;
         end else if (bus.exception_type_i[5]) begin
            exc_code = 5'h04;
            bad_wr   = 1'b1;
            bad_val  = bus.bad_addr_i;
         end else if (bus.exception_type_i[6]) begin
            exc_code = 5'h05;
            bad_wr   = 1'b1;
            bad_val  = bus.bad_addr_i;
         end else if (bus.eret_i) begin
            is_eret = 1'b1;
         end else begin
            accept = 1'b0;
         end
      end

      // MTC0 is dropped while squashing and when an event wins the commit slot.
      wr_en = bus.cp0_write_enable_i && (state_q == StRun) && !accept;

      tick = (presc_q == DivLast);
      ti   = cause_q[30];
      if (wr_en && bus.cp0_write_addr_i == AddrCount) begin
         count_d = bus.cp0_write_data_i;
         presc_d = '0;
      end else begin
         count_d = count_q + {31'b0, tick};
         presc_d = tick ? '0 : presc_q + 32'd1;
         if (tick && count_d == compare_q) ti = 1'b1;
      end
      if (wr_en && bus.cp0_write_addr_i == AddrCompare) begin
         compare_d = bus.cp0_write_data_i;
         ti        = 1'b0;
      end
      if (wr_en && bus.cp0_write_addr_i == AddrStatus) begin
         status_d = (status_q & ~StatusMask) | (bus.cp0_write_data_i & StatusMask);
      end
      if (wr_en && bus.cp0_write_addr_i == AddrCause) begin
         cause_d = (cause_q & ~CauseMask) | (bus.cp0_write_data_i & CauseMask);
      end
      if (wr_en && bus.cp0_write_addr_i == AddrEpc) epc_d = bus.cp0_write_data_i;

      if (accept) begin
         flush_d = 1'b1;
         state_d = StSquash;
         if (is_eret) begin
            status_d[1] = 1'b0;
            ret_pc_d    = epc_q;
         end else begin
            // Nested exceptions keep the original EPC/BD so the outer handler can return.
            if (!status_q[1]) begin
               epc_d       = (is_int || !bus.in_delayslot_i) ? bus.pc_i : bus.pc_i - 32'd4;
               cause_d[31] = bus.in_delayslot_i;
            end
            status_d[1]   = 1'b1;
            cause_d[6:2]  = exc_code;
            ret_pc_d      = EXC_VECTOR;
            if (bad_wr) badvaddr_d = bad_val;
         end
      end

      cause_d[30]    = ti;
      cause_d[14:10] = int_ext[4:0];
      cause_d[15]    = ti | int_ext[5];
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= StRun;
         badvaddr_q <= '0;
         count_q    <= '0;
         compare_q  <= '0;
         status_q   <= StatusReset;
         cause_q    <= '0;
         epc_q      <= '0;
         presc_q    <= '0;
         flush_q    <= 1'b0;
         ret_pc_q   <= '0;
      end else begin
         state_q    <= state_d;
         badvaddr_q <= badvaddr_d;
         count_q    <= count_d;
         compare_q  <= compare_d;
         status_q   <= status_d;
         cause_q    <= cause_d;
         epc_q      <= epc_d;
         presc_q    <= presc_d;
         flush_q    <= flush_d;
         ret_pc_q   <= ret_pc_d;
      end
   end

   assign bus.cp0_read_data_o = rd_data;
   assign bus.cp0_return_pc_o = ret_pc_q;
   assign bus.flush_o         = flush_q;
   assign bus.timer_int_o     = cause_q[30];
   assign bus.cp0_status_o    = status_q;
   assign bus.cp0_cause_o     = cause_q;
   assign bus.cp0_epc_o       = epc_q;
endmodule

// File: tb/tb_cp0_exc_unit.sv
// Randomised and directed bench for cp0_exc_unit against an event-level model of CP0.
module tb_cp0_exc_unit;
   localparam int unsigned HW = 6;
   localparam int unsigned DIV = 2;
   localparam logic [31:0] VEC = 32'hBFC0_0380;

   logic clk = 1'b0;
   logic rst = 1'b0;
   int   n_cmp = 0;
   int   n_fail = 0;

   cp0_exc_unit_if #(.HW_INT_NUM(HW)) bus ();

   cp0_exc_unit #(.HW_INT_NUM(HW), .COUNT_DIV(DIV), .EXC_VECTOR(VEC)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   // Architectural model state
   logic [31:0] m_bad, m_count, m_compare, m_status, m_cause, m_epc, m_ret;
   int unsigned m_presc;
   bit          m_squash, m_flush;
   int unsigned code_tab [7] = '{4, 10, 12, 9, 8, 4, 5};

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_bad = 0; m_count = 0; m_compare = 0; m_status = 32'h0040_0000; m_cause = 0;
      m_epc = 0; m_ret = 0; m_presc = 0; m_squash = 0; m_flush = 0;
   endtask

   function automatic logic [31:0] m_read();
      logic [31:0] r;
      logic [31:0] wd;
      wd = bus.cp0_write_data_i;
      case (bus.cp0_read_addr_i)
         5'd8: r = m_bad;
         5'd9: r = m_count;
         5'd11: r = m_compare;
         5'd12: r = m_status;
         5'd13: r = m_cause;
         5'd14: r = m_epc;
         default: r = 0;
      endcase
      if (bus.cp0_write_enable_i && bus.cp0_write_addr_i == bus.cp0_read_addr_i) begin
         case (bus.cp0_read_addr_i)
            5'd9, 5'd11, 5'd14: r = wd;
            5'd12: r = {m_status[31:16], wd[15:8], m_status[7:2], wd[1:0]};
            5'd13: r = {m_cause[31:10], wd[9:8], m_cause[7:0]};
            default: ;
         endcase
      end
      return r;
   endfunction

   // One clock edge of the architecture: ev -1 none, 0..6 exception bit, 7 interrupt, 8 ERET.
   task automatic model_step();
      logic [31:0] n_count, n_compare, n_status, n_cause, n_epc, n_bad, wd, pc;
      int ev;
      bit wr, inc, ti;
      logic [4:0] wa;
      n_count = m_count; n_compare = m_compare; n_status = m_status; n_cause = m_cause;
      n_epc = m_epc; n_bad = m_bad;
      wd = bus.cp0_write_data_i; wa = bus.cp0_write_addr_i; pc = bus.pc_i;
      ev = -1;
      if (!m_squash) begin
         if (((m_cause[15:8] & m_status[15:8]) != 0) && m_status[0] && !m_status[1]
             && bus.inst_valid_i) ev = 7;
         else begin
            for (int k = 6; k >= 0; k--) if (bus.exception_type_i[k]) ev = k;
            if (ev < 0 && bus.eret_i) ev = 8;
         end
      end
      wr = !m_squash && ev < 0 && bus.cp0_write_enable_i;
      inc = (m_presc == DIV - 1);
      ti = m_cause[30];
      if (wr && wa == 9) begin
         n_count = wd;
         m_presc = 0;
      end else begin
         n_count = m_count + (inc ? 32'd1 : 32'd0);
         m_presc = inc ? 0 : m_presc + 1;
         if (inc && n_count == m_compare) ti = 1;
      end
      if (wr && wa == 11) begin n_compare = wd; ti = 0; end
      if (wr && wa == 12) n_status = {m_status[31:16], wd[15:8], m_status[7:2], wd[1:0]};
      if (wr && wa == 13) n_cause[9:8] = wd[9:8];
      if (wr && wa == 14) n_epc = wd;
      m_ret = 0;
      if (ev == 8) begin
         n_status[1] = 0;
         m_ret = m_epc;
      end else if (ev >= 0) begin
         if (!m_status[1]) begin
            n_epc = (ev == 7) ? pc : (bus.in_delayslot_i ? pc - 4 : pc);
            n_cause[31] = bus.in_delayslot_i;
         end
         n_status[1] = 1;
         n_cause[6:2] = (ev == 7) ? 5'd0 : 5'(code_tab[ev]);
         if (ev == 0) n_bad = pc;
         if (ev == 5 || ev == 6) n_bad = bus.bad_addr_i;
         m_ret = VEC;
      end
      n_cause[30] = ti;
      n_cause[15:10] = {ti | bus.int_i[5], bus.int_i[4:0]};
      m_count = n_count; m_compare = n_compare; m_status = n_status; m_cause = n_cause;
      m_epc = n_epc; m_bad = n_bad;
      m_flush = (ev >= 0);
      m_squash = (ev >= 0);
   endtask

   task automatic check_regs();
      chk("status", bus.cp0_status_o, m_status);
      chk("cause", bus.cp0_cause_o, m_cause);
      chk("epc", bus.cp0_epc_o, m_epc);
      chk("flush", 32'(bus.flush_o), 32'(m_flush));
      chk("timer_int", 32'(bus.timer_int_o), 32'(m_cause[30]));
      if (m_flush) chk("return_pc", bus.cp0_return_pc_o, m_ret);
   endtask

   // Inputs are already driven (at a negedge); compare comb read, advance model, compare regs.
   task automatic tick();
      #1;
      chk("mfc0", bus.cp0_read_data_o, m_read());
      model_step();
      @(negedge clk);
      check_regs();
   endtask

   task automatic idle();
      bus.cp0_read_addr_i = 0; bus.cp0_write_enable_i = 0; bus.cp0_write_addr_i = 0;
      bus.cp0_write_data_i = 0; bus.inst_valid_i = 0; bus.exception_type_i = 0;
      bus.eret_i = 0; bus.pc_i = 0; bus.bad_addr_i = 0; bus.in_delayslot_i = 0; bus.int_i = 0;
   endtask

   task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
      idle();
      bus.cp0_write_enable_i = 1; bus.cp0_write_addr_i = a; bus.cp0_write_data_i = d;
      tick();
   endtask

   function automatic logic [4:0] pick_addr();
      logic [4:0] tab [7];
      tab = '{5'd8, 5'd9, 5'd11, 5'd12, 5'd13, 5'd14, 5'd0};
      tab[6] = 5'($urandom);
      return tab[$urandom_range(0, 6)];
   endfunction

   initial begin
      idle();
      model_reset();
      @(negedge clk);
      check_regs();
      chk("reset_status", bus.cp0_status_o, 32'h0040_0000);
      rst = 1'b1;

      // Timer interrupt taken at a valid commit
      mtc0(5'd12, 32'h0000_8001);
      mtc0(5'd11, 32'd5);
      mtc0(5'd9, 32'd0);
      idle();
      for (int i = 1; i <= 10; i++) begin
         tick();
         if (i == 9) chk("tp1_ti_early", 32'(bus.timer_int_o), 32'd0);
      end
      chk("tp1_ti_rise", 32'(bus.timer_int_o), 32'd1);
      bus.inst_valid_i = 1; bus.pc_i = 32'h80;
      tick();
      chk("tp1_flush", 32'(bus.flush_o), 32'd1);
      chk("tp1_ret", bus.cp0_return_pc_o, 32'hBFC0_0380);
      chk("tp1_epc", bus.cp0_epc_o, 32'h80);
      chk("tp1_code", 32'(bus.cp0_cause_o[6:2]), 32'h0);
      chk("tp1_exl", 32'(bus.cp0_status_o[1]), 32'd1);
      idle();
      tick();
      mtc0(5'd11, 32'd1000);
      chk("tp1_ti_clear", 32'(bus.timer_int_o), 32'd0);

      // RI+Ov in a delay slot, EXL=0
      mtc0(5'd12, 32'h0);
      idle();
      bus.exception_type_i = 7'b0000110; bus.in_delayslot_i = 1; bus.pc_i = 32'h1004;
      bus.inst_valid_i = 1;
      tick();
      chk("tp2_code", 32'(bus.cp0_cause_o[6:2]), 32'h0A);
      chk("tp2_epc", bus.cp0_epc_o, 32'h1000);
      chk("tp2_bd", 32'(bus.cp0_cause_o[31]), 32'd1);
      chk("tp2_flush", 32'(bus.flush_o), 32'd1);
      idle();
      tick();
      chk("tp2_flush_end", 32'(bus.flush_o), 32'd0);

      // AdES while EXL=1
      bus.exception_type_i = 7'b1000000; bus.bad_addr_i = 32'h2003; bus.pc_i = 32'h5000;
      tick();
      chk("tp3_epc", bus.cp0_epc_o, 32'h1000);
      chk("tp3_bd", 32'(bus.cp0_cause_o[31]), 32'd1);
      chk("tp3_code", 32'(bus.cp0_cause_o[6:2]), 32'h05);
      chk("tp3_ret", bus.cp0_return_pc_o, 32'hBFC0_0380);
      idle();
      bus.cp0_read_addr_i = 5'd8;
      #1 chk("tp3_badvaddr", bus.cp0_read_data_o, 32'h2003);
      tick();

      // ERET to an MTC0-written EPC, Sys in the squash cycle ignored
      mtc0(5'd14, 32'h3000);
      idle();
      bus.eret_i = 1;
      tick();
      chk("tp4_flush", 32'(bus.flush_o), 32'd1);
      chk("tp4_ret", bus.cp0_return_pc_o, 32'h3000);
      chk("tp4_exl", 32'(bus.cp0_status_o[1]), 32'd0);
      idle();
      bus.exception_type_i = 7'b0010000;
      tick();
      chk("tp4_squash", 32'(bus.flush_o), 32'd0);
      chk("tp4_code_kept", 32'(bus.cp0_cause_o[6:2]), 32'h05);

      // Status write bypass
      idle();
      bus.cp0_write_enable_i = 1; bus.cp0_write_addr_i = 5'd12;
      bus.cp0_write_data_i = 32'hFFFF_FFFF; bus.cp0_read_addr_i = 5'd12;
      #1 chk("tp5_bypass", bus.cp0_read_data_o, 32'h0040_FF03);
      tick();
      chk("tp5_status", bus.cp0_status_o, 32'h0040_FF03);

      // Random traffic
      for (int i = 0; i < 4000; i++) begin
         idle();
         bus.cp0_read_addr_i = pick_addr();
         bus.cp0_write_enable_i = ($urandom_range(0, 3) == 0);
         bus.cp0_write_addr_i = pick_addr();
         bus.cp0_write_data_i = $urandom;
         if (bus.cp0_write_addr_i == 5'd11) bus.cp0_write_data_i = m_count + $urandom_range(0, 8);
         bus.inst_valid_i = 1'($urandom);
         if ($urandom_range(0, 5) == 0) bus.exception_type_i = 7'($urandom);
         bus.eret_i = ($urandom_range(0, 7) == 0);
         bus.pc_i = {$urandom_range(0, 32'h3FFF_FFFF), 2'b00};
         bus.bad_addr_i = $urandom;
         bus.in_delayslot_i = 1'($urandom);
         if ($urandom_range(0, 3) == 0) bus.int_i = 6'($urandom);
         tick();
      end

      // Reset in the middle of a flush
      idle();
      bus.exception_type_i = 7'b0001000;
      tick();
      if (!m_flush) begin
         // EXL state from random traffic does not matter; squash may have blocked the Bp
         idle();
         bus.exception_type_i = 7'b0001000;
         tick();
      end
      chk("tp6_flush_pre", 32'(bus.flush_o), 32'd1);
      rst = 1'b0;
      #1;
      chk("tp6_flush", 32'(bus.flush_o), 32'd0);
      chk("tp6_ret", bus.cp0_return_pc_o, 32'd0);
      chk("tp6_status", bus.cp0_status_o, 32'h0040_0000);
      chk("tp6_cause", bus.cp0_cause_o, 32'd0);
      chk("tp6_epc", bus.cp0_epc_o, 32'd0);
      model_reset();
      idle();
      @(negedge clk);
      rst = 1'b1;
      bus.exception_type_i = 7'b0010000;
      tick();
      chk("tp6_run", 32'(bus.flush_o), 32'd1);

      $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
      $finish;
   end
endmodule
